// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I multicycle core.
// Opcodes, funct3 codes, FSM states and ALU operations.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 integer register file: two async reads, one sync write.
// x0 always reads as zero and ignores writes.
module cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    logic [31:0] regs [32];

    // Combinational read ports with x0 forced to zero
    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];
    end

    // Register write at the end of the writing state
    always_ff @(posedge clk) begin
        if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end

endmodule

// File: rtl/cpu.sv
// RV32I multicycle core: FETCH -> EXEC (-> MEM) over one shared bus.
// Decode, ALU and control FSM live here; registers in cpu_regfile.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_memaddr,
    output logic        o_memwrite,
    output logic        o_memread,
    input  logic [31:0] i_membus,
    output logic [31:0] o_memwdata,
    output logic [3:0]  o_memwmask
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic [31:0] ea_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        f7b5;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc_plus4;

    alu_op_t     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        br_take;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] st_data;
    logic [3:0]  st_mask;

    logic        rf_we;
    logic [31:0] rf_wdata;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7b5   = ir_q[30];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                    ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'd0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                    ir_q[20], ir_q[30:21], 1'b0};

    assign pc_plus4 = pc_q + 32'd4;

    cpu_regfile u_rf (
        .clk      (i_clk),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (rf_we),
        .rd_addr  (rd),
        .rd_data  (rf_wdata)
    );

    // ALU operation and second operand select for OP / OP-IMM
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
        case (f3)
            F3_ADD:  alu_op = (opcode == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = f7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // ALU datapath; shifts use the low five bits of the operand
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_res = rs1_val + alu_b;
            ALU_SUB:  alu_res = rs1_val - alu_b;
            ALU_SLL:  alu_res = rs1_val << alu_b[4:0];
            ALU_SLT:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'd0, rs1_val < alu_b};
            ALU_XOR:  alu_res = rs1_val ^ alu_b;
            ALU_SRL:  alu_res = rs1_val >> alu_b[4:0];
            ALU_SRA:  alu_res = $signed(rs1_val) >>> alu_b[4:0];
            ALU_OR:   alu_res = rs1_val | alu_b;
            ALU_AND:  alu_res = rs1_val & alu_b;
            default:  alu_res = 32'd0;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        case (f3)
            F3_BEQ:  br_take = (rs1_val == rs2_val);
            F3_BNE:  br_take = (rs1_val != rs2_val);
            F3_BLT:  br_take = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_take = (rs1_val < rs2_val);
            F3_BGEU: br_take = (rs1_val >= rs2_val);
            default: br_take = 1'b0;
        endcase
    end

    // Load lane extraction and store lane replication/masks
    always_comb begin
        ld_byte = i_membus[{ea_q[1:0], 3'b000} +: 8];
        ld_half = ea_q[1] ? i_membus[31:16] : i_membus[15:0];
        case (f3)
            F3_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_val = {24'd0, ld_byte};
            F3_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = i_membus;
        endcase
        case (f3)
            F3_SB: begin
                st_data = {4{rs2_val[7:0]}};
                st_mask = 4'b0001 << ea_q[1:0];
            end
            F3_SH: begin
                st_data = {2{rs2_val[15:0]}};
                st_mask = 4'b0011 << {ea_q[1], 1'b0};
            end
            default: begin
                st_data = rs2_val;
                st_mask = 4'b1111;
            end
        endcase
    end

    // Next-state, pc update, register write and bus outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rf_we      = 1'b0;
        rf_wdata   = alu_res;
        o_memaddr  = pc_q;
        o_memread  = 1'b0;
        o_memwrite = 1'b0;
        o_memwdata = 32'd0;
        o_memwmask = 4'd0;
        unique case (state_q)
            S_FETCH: begin
                o_memread = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OPC_LOAD, OPC_STORE: begin
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    OPC_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_u;
                    end
                    OPC_AUIPC: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + imm_u;
                    end
                    OPC_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_d     = pc_q + imm_j;
                    end
                    OPC_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_d     = (rs1_val + imm_i) & ~32'd1;
                    end
                    OPC_BRANCH: begin
                        if (br_take) pc_d = pc_q + imm_b;
                    end
                    OPC_OP, OPC_OP_IMM: begin
                        rf_we = 1'b1;
                    end
                    OPC_MISC_MEM, OPC_SYSTEM: begin
                        rf_we = 1'b0;
                    end
                    default: begin
                        rf_we = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                o_memaddr = {ea_q[31:2], 2'b00};
                pc_d      = pc_plus4;
                state_d   = S_FETCH;
                if (opcode == OPC_LOAD) begin
                    o_memread = 1'b1;
                    rf_we     = 1'b1;
                    rf_wdata  = ld_val;
                end else begin
                    o_memwrite = 1'b1;
                    o_memwdata = st_data;
                    o_memwmask = st_mask;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (i_reset) begin
            rf_we      = 1'b0;
            o_memaddr  = RESET_PC;
            o_memread  = 1'b1;
            o_memwrite = 1'b0;
            o_memwdata = 32'd0;
            o_memwmask = 4'd0;
        end
    end

    // State, pc, instruction and effective-address registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_FETCH) begin
                ir_q <= i_membus;
            end
            if (state_q == S_EXEC) begin
                ea_q <= rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the RV32I multicycle core.
// Small word memory model, hand-encoded programs, fixed timelines.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memaddr;
    logic        memwrite;
    logic        memread;
    logic [31:0] membus;
    logic [31:0] memwdata;
    logic [3:0]  memwmask;

    logic [31:0] mem [256];
    int          nstores = 0;
    int          checks = 0;
    int          failures = 0;
    int          s0;

    cpu dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .o_memaddr  (memaddr),
        .o_memwrite (memwrite),
        .o_memread  (memread),
        .i_membus   (membus),
        .o_memwdata (memwdata),
        .o_memwmask (memwmask)
    );

    always #5 clk = ~clk;

    assign membus = (memaddr[31:10] == 22'h200000) ? mem[memaddr[9:2]] : 32'd0;

    always @(posedge clk) begin
        if (memwrite) begin
            nstores++;
            if (memaddr[31:10] == 22'h200000) begin
                for (int b = 0; b < 4; b++) begin
                    if (memwmask[b]) mem[memaddr[9:2]][8*b +: 8] = memwdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
            $error("%s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic load_start();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic release_rst();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] rg(input int i);
        return dut.u_rf.regs[i];
    endfunction

    initial begin
        // addi x1,x0,5
        load_start();
        mem[0] = 32'h0050_0093;
        @(posedge clk);
        #1;
        chk("rst_addr", memaddr, 32'h8000_0000);
        chk("rst_read", {31'd0, memread}, 32'd1);
        chk("rst_wr", {31'd0, memwrite}, 32'd0);
        chk("rst_mask", {28'd0, memwmask}, 32'd0);
        release_rst();
        chk("f0_addr", memaddr, 32'h8000_0000);
        chk("f0_read", {31'd0, memread}, 32'd1);
        tick(1);
        chk("exec_read", {31'd0, memread}, 32'd0);
        tick(1);
        chk("f1_addr", memaddr, 32'h8000_0004);
        chk("addi_x1", rg(1), 32'd5);

        // ALU program
        load_start();
        mem[0]  = 32'hFFF0_0093;
        mem[1]  = 32'h0010_3133;
        mem[2]  = 32'h4040_D193;
        mem[3]  = 32'h0090_0213;
        mem[4]  = 32'h0070_0013;
        mem[5]  = 32'h0000_0233;
        mem[6]  = 32'h4010_02B3;
        mem[7]  = 32'h0000_A333;
        mem[8]  = 32'h0F00_F393;
        mem[9]  = 32'h5550_C413;
        mem[10] = 32'h1230_6493;
        mem[11] = 32'h01F2_9513;
        mem[12] = 32'h01C0_D593;
        release_rst();
        tick(8);
        chk("x4_nine", rg(4), 32'd9);
        tick(18);
        chk("x1_m1", rg(1), 32'hFFFF_FFFF);
        chk("sltu_x2", rg(2), 32'd1);
        chk("srai_x3", rg(3), 32'hFFFF_FFFF);
        chk("x0_add_x4", rg(4), 32'd0);
        chk("sub_x5", rg(5), 32'd1);
        chk("slt_x6", rg(6), 32'd1);
        chk("andi_x7", rg(7), 32'h0000_00F0);
        chk("xori_x8", rg(8), 32'hFFFF_FAAA);
        chk("ori_x9", rg(9), 32'h0000_0123);
        chk("slli_x10", rg(10), 32'h8000_0000);
        chk("srli_x11", rg(11), 32'h0000_000F);

        // beq taken
        load_start();
        mem[2] = 32'h0000_0463;
        release_rst();
        tick(6);
        chk("beq_pc", memaddr, 32'h8000_0010);

        // bne not taken
        load_start();
        mem[2] = 32'h0000_1463;
        release_rst();
        tick(6);
        chk("bne_pc", memaddr, 32'h8000_000C);

        // blt not taken, bltu taken
        load_start();
        mem[0] = 32'hFFF0_0093;
        mem[1] = 32'h0010_4463;
        mem[2] = 32'h0010_6463;
        release_rst();
        tick(4);
        chk("blt_pc", memaddr, 32'h8000_0008);
        tick(2);
        chk("bltu_pc", memaddr, 32'h8000_0010);

        // jal / jalr
        load_start();
        mem[0] = 32'h0100_00EF;
        mem[4] = 32'h0000_8067;
        release_rst();
        tick(2);
        chk("jal_pc", memaddr, 32'h8000_0010);
        chk("jal_x1", rg(1), 32'h8000_0004);
        tick(2);
        chk("jalr_pc", memaddr, 32'h8000_0004);

        // loads from 0x8000_0100
        load_start();
        mem[0]  = 32'h8000_0337;
        mem[1]  = 32'h1003_0283;
        mem[2]  = 32'h1013_0383;
        mem[3]  = 32'h1023_5403;
        mem[4]  = 32'h1023_1483;
        mem[5]  = 32'h1003_2503;
        mem[6]  = 32'h1013_4583;
        mem[64] = 32'h8001_FF7F;
        release_rst();
        tick(4);
        chk("lb_addr", memaddr, 32'h8000_0100);
        chk("lb_read", {31'd0, memread}, 32'd1);
        chk("lb_wr", {31'd0, memwrite}, 32'd0);
        tick(1);
        chk("ld_next_pc", memaddr, 32'h8000_0008);
        tick(2);
        chk("lb1_addr", memaddr, 32'h8000_0100);
        tick(13);
        chk("lb_x5", rg(5), 32'h0000_007F);
        chk("lb_x7", rg(7), 32'hFFFF_FFFF);
        chk("lhu_x8", rg(8), 32'h0000_8001);
        chk("lh_x9", rg(9), 32'hFFFF_8001);
        chk("lw_x10", rg(10), 32'h8001_FF7F);
        chk("lbu_x11", rg(11), 32'h0000_00FF);

        // stores to 0x8000_0200
        load_start();
        mem[0] = 32'h0AB0_0093;
        mem[1] = 32'h8000_0137;
        mem[2] = 32'h2001_0113;
        mem[3] = 32'h0011_01A3;
        mem[4] = 32'h0011_1123;
        mem[5] = 32'h0011_2023;
        mem[128] = 32'h0000_0000;
        release_rst();
        s0 = nstores;
        tick(8);
        chk("sb_wr", {31'd0, memwrite}, 32'd1);
        chk("sb_addr", memaddr, 32'h8000_0200);
        chk("sb_mask", {28'd0, memwmask}, 32'h8);
        chk("sb_data", memwdata, 32'hABAB_ABAB);
        tick(1);
        chk("sb_pulse", {31'd0, memwrite}, 32'd0);
        chk("idle_mask", {28'd0, memwmask}, 32'd0);
        chk("sb_count", nstores - s0, 32'd1);
        tick(2);
        chk("sh_mask", {28'd0, memwmask}, 32'hC);
        chk("sh_data", memwdata, 32'h00AB_00AB);
        tick(1);
        chk("mem_after_sh", mem[128], 32'h00AB_0000);
        tick(2);
        chk("sw_mask", {28'd0, memwmask}, 32'hF);
        chk("sw_data", memwdata, 32'h0000_00AB);
        tick(1);
        chk("mem_after_sw", mem[128], 32'h0000_00AB);

        // reset asserted during the sb MEM cycle
        load_start();
        mem[0] = 32'h0AB0_0093;
        mem[1] = 32'h8000_0137;
        mem[2] = 32'h2001_0113;
        mem[3] = 32'h0011_01A3;
        mem[128] = 32'h1122_3344;
        release_rst();
        tick(8);
        chk("pre_rst_wr", {31'd0, memwrite}, 32'd1);
        s0 = nstores;
        rst = 1'b1;
        #1;
        chk("mrst_wr", {31'd0, memwrite}, 32'd0);
        chk("mrst_addr", memaddr, 32'h8000_0000);
        chk("mrst_mask", {28'd0, memwmask}, 32'd0);
        tick(1);
        rst = 1'b0;
        #1;
        chk("mrst_fetch", memaddr, 32'h8000_0000);
        chk("mrst_wr2", {31'd0, memwrite}, 32'd0);
        tick(3);
        chk("mrst_nostore", nstores - s0, 32'd0);
        chk("mrst_mem", mem[128], 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
